fir_coef_loader: RTL and testbench



---
 rtl/fir_pkg.sv | 11 +
 rtl/fir_coef_loader_if.sv | 13 +
 rtl/fir_coef_loader.sv | 101 ++++++++++
 tb/tb_fir_coef_loader.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR definitions: default widths and the coefficient-loader state type.
package fir_pkg;
    localparam int FIR_N      = 32;
    localparam int FIR_DELAYS = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } coef_state_t;
endpackage

// File: rtl/fir_coef_loader_if.sv
// Coefficient word stream (valid/ready) feeding the FIR coefficient loader.
interface fir_coef_loader_if
    import fir_pkg::*;
#(
    parameter int N = FIR_N
);
    logic [N-1:0] coef_in;
    logic         coef_valid;
    logic         coef_ready;

    modport master (output coef_in, output coef_valid, input coef_ready);
    modport slave  (input coef_in, input coef_valid, output coef_ready);
endinterface

// File: rtl/fir_coef_loader.sv
// Streams FIR coefficients into a shadow bank, then commits the full set to b in one cycle
// so the taps never observe a partially written set.
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int DELAYS = FIR_DELAYS,
    parameter int N      = FIR_N
) (
    input  logic                      clk,
    input  logic                      rst,
    fir_coef_loader_if.slave          cif,
    input  logic                      load_start,
    input  logic                      abort,
    output logic [(DELAYS+1)*N-1:0]   b,
    output logic                      busy,
    output logic                      loaded,
    output logic                      commit_pulse,
    output logic                      err
);
    localparam int TAPS  = DELAYS + 1;
    localparam int CNT_W = $clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TAPS - 1);

    coef_state_t      state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic [N-1:0]     shadow_q [TAPS];
    logic             beat;
    logic             store;

    assign cif.coef_ready = (state_q == LOAD);
    assign busy           = (state_q != IDLE);
    assign beat           = cif.coef_valid && cif.coef_ready;
    // abort and restart both outrank a beat arriving in the same cycle
    assign store          = beat && !abort && !load_start;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_start) state_d = LOAD;
            LOAD: begin
                if (abort)                         state_d = IDLE;
                else if (load_start)               state_d = LOAD;
                else if (beat && count_q == LAST)  state_d = COMMIT;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            err          <= 1'b0;
            loaded       <= 1'b0;
            commit_pulse <= 1'b0;
        end else begin
            commit_pulse <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_start) begin
                        count_q <= '0;
                        err     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        err <= 1'b1;
                    end else if (load_start) begin
                        count_q <= '0;
                        err     <= 1'b1;
                    end else if (beat && count_q != LAST) begin
                        count_q <= count_q + 1'b1;
                    end
                end
                COMMIT: begin
                    commit_pulse <= 1'b1;
                    loaded       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---- shadow bank write / atomic commit to the active bus ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) shadow_q[i] <= '0;
            b <= '0;
        end else begin
            if (state_q == LOAD && store) shadow_q[count_q] <= cif.coef_in;
            if (state_q == COMMIT) begin
                for (int i = 0; i < TAPS; i++) b[i*N +: N] <= shadow_q[i];
            end
        end
    end
endmodule

// File: tb/tb_fir_coef_loader.sv
// Bench for fir_coef_loader: directed scenarios plus random traffic against a queue-based model.
module tb_fir_coef_loader;
    localparam int DELAYS = 3;
    localparam int N      = 32;
    localparam int TAPS   = DELAYS + 1;
    localparam int BW     = TAPS * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic          abort;
    logic [BW-1:0] b;
    logic          busy, loaded, commit_pulse, err;

    fir_coef_loader_if #(.N(N)) cif ();

    fir_coef_loader #(.DELAYS(DELAYS), .N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .cif          (cif),
        .load_start   (load_start),
        .abort        (abort),
        .b            (b),
        .busy         (busy),
        .loaded       (loaded),
        .commit_pulse (commit_pulse),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: is a load collecting words, the words gathered so far,
    // and whether the next edge is the single commit cycle.
    bit            m_loading;
    bit            m_commit;
    logic [N-1:0]  m_words[$];
    logic [BW-1:0] m_b;
    bit            m_loaded, m_pulse, m_err;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic ls, input logic ab,
                              input logic cv, input logic [N-1:0] d);
        if (r) begin
            m_loading = 0; m_commit = 0; m_words.delete();
            m_b = '0; m_loaded = 0; m_pulse = 0; m_err = 0;
        end else if (m_commit) begin
            for (int i = 0; i < TAPS; i++) m_b[i*N +: N] = m_words[i];
            m_words.delete();
            m_commit = 0; m_pulse = 1; m_loaded = 1;
        end else begin
            m_pulse = 0;
            if (m_loading) begin
                if (ab) begin
                    m_loading = 0; m_err = 1; m_words.delete();
                end else if (ls) begin
                    m_err = 1; m_words.delete();
                end else if (cv) begin
                    m_words.push_back(d);
                    if (m_words.size() == TAPS) begin
                        m_loading = 0; m_commit = 1;
                    end
                end
            end else if (ls) begin
                m_loading = 1; m_err = 0; m_words.delete();
            end
        end
    endtask

    task automatic check_all();
        chk("coef_ready",   BW'(cif.coef_ready), BW'(m_loading));
        chk("busy",         BW'(busy),           BW'(m_loading || m_commit));
        chk("b",            b,                   m_b);
        chk("loaded",       BW'(loaded),         BW'(m_loaded));
        chk("commit_pulse", BW'(commit_pulse),   BW'(m_pulse));
        chk("err",          BW'(err),            BW'(m_err));
    endtask

    task automatic step(input logic r, input logic ls, input logic ab,
                        input logic cv, input logic [N-1:0] d);
        rst = r; load_start = ls; abort = ab; cif.coef_valid = cv; cif.coef_in = d;
        model_edge(r, ls, ab, cv, d);
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        step(0, 0, 0, 0, '0);
    endtask

    task automatic beat(input logic [N-1:0] d);
        step(0, 0, 0, 1, d);
    endtask

    localparam logic [BW-1:0] SET_A = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [BW-1:0] SET_B = {32'd12, 32'd11, 32'd10, 32'd9};

    initial begin
        rst = 1; load_start = 0; abort = 0;
        cif.coef_valid = 0; cif.coef_in = '0;
        m_b = '0; m_loading = 0; m_commit = 0; m_loaded = 0; m_pulse = 0; m_err = 0;
        @(negedge clk);
        step(1, 0, 0, 0, '0);
        step(1, 0, 0, 0, '0);
        chk("reset_b", b, '0);
        chk("reset_flags", BW'({busy, loaded, commit_pulse, err, cif.coef_ready}), '0);

        // basic back-to-back load; DEADBEEF offered during COMMIT and IDLE must be ignored
        step(0, 1, 0, 0, '0);
        for (int i = 1; i <= TAPS; i++) beat(N'(i));
        chk("basic_pre_commit_b", b, '0);
        step(0, 1, 1, 1, 32'hDEADBEEF);
        chk("basic_b", b, SET_A);
        chk("basic_pulse", BW'(commit_pulse), BW'(1));
        step(0, 0, 0, 1, 32'hDEADBEEF);
        chk("basic_busy_after", BW'(busy), BW'(0));
        chk("idle_ignore_b", b, SET_A);

        // same values with 3-cycle gaps
        step(0, 1, 0, 0, '0);
        for (int i = 1; i <= TAPS; i++) begin
            for (int g = 0; g < 3; g++) begin
                idle_cycle();
                chk("gap_ready", BW'(cif.coef_ready), BW'(1));
            end
            beat(N'(i));
        end
        idle_cycle();
        chk("gap_b", b, SET_A);
        idle_cycle();

        // abort after two words
        step(0, 1, 0, 0, '0);
        beat(32'd5); beat(32'd6);
        step(0, 0, 1, 1, 32'd77);
        chk("abort_err", BW'(err), BW'(1));
        chk("abort_b", b, SET_A);
        idle_cycle(); idle_cycle();
        chk("abort_b_hold", b, SET_A);

        // restart mid-load with a colliding beat
        step(0, 1, 0, 0, '0);
        beat(32'd7); beat(32'd8);
        step(0, 1, 0, 1, 32'd99);
        beat(32'd9); beat(32'd10); beat(32'd11); beat(32'd12);
        idle_cycle();
        chk("restart_b", b, SET_B);
        chk("restart_err", BW'(err), BW'(1));
        step(0, 1, 0, 0, '0);
        chk("restart_err_clear", BW'(err), BW'(0));

        // reset mid-load, then a clean load
        beat(32'd21); beat(32'd22);
        step(1, 0, 0, 1, 32'd23);
        chk("rst_b", b, '0);
        chk("rst_loaded", BW'(loaded), BW'(0));
        step(0, 1, 0, 0, '0);
        for (int i = 1; i <= TAPS; i++) beat(N'(i + 8));
        idle_cycle();
        chk("post_rst_b", b, SET_B);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            logic r, ls, ab, cv;
            r  = ($urandom_range(0, 199) == 0);
            ls = ($urandom_range(0, 99) < 6);
            ab = ($urandom_range(0, 99) < 3);
            cv = ($urandom_range(0, 99) < 60);
            step(r, ls, ab, cv, N'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
